// File: rtl/sync_fork3_issue.sv
// sync_fork3_issue: valid/ready issue stage that fans one token out to three
// micropipeline branches and holds off the next token until all three free returns arrive.
module sync_fork3_issue #(
  parameter int DW      = 8,
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 16,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_drive0,
  output logic          o_drive1,
  output logic          o_drive2,
  input  logic          i_free0,
  input  logic          i_free1,
  input  logic          i_free2,
  output logic          o_busy,
  output logic          o_err,
  output logic [CW-1:0] o_tokCnt
);

  localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_W - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  state_t        state, state_nx;
  logic [2:0]    free_s1, free_s2, free_prev;
  logic [2:0]    free_edge;
  logic [2:0]    flags, flags_nx;
  logic          all_set;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic [WW-1:0] wcnt, wcnt_nx;
  logic          drive_q, drive_nx;
  logic          ready_nx, busy_nx, err_nx;
  logic [DW-1:0] data_nx;
  logic [CW-1:0] tok_nx;

  // Frees are asynchronous: two-stage synchronizer, then a one-cycle rising-edge strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_s1   <= '0;
      free_s2   <= '0;
      free_prev <= '0;
    end else begin
      free_s1   <= {i_free2, i_free1, i_free0};
      free_s2   <= free_s1;
      free_prev <= free_s2;
    end
  end

  assign free_edge = free_s2 & ~free_prev;
  assign all_set   = &(flags | free_edge);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      flags    <= '0;
      pcnt     <= '0;
      wcnt     <= '0;
      drive_q  <= 1'b0;
      o_ready  <= 1'b0;
      o_busy   <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      o_tokCnt <= '0;
    end else begin
      state    <= state_nx;
      flags    <= flags_nx;
      pcnt     <= pcnt_nx;
      wcnt     <= wcnt_nx;
      drive_q  <= drive_nx;
      o_ready  <= ready_nx;
      o_busy   <= busy_nx;
      o_err    <= err_nx;
      o_data   <= data_nx;
      o_tokCnt <= tok_nx;
    end
  end

  // Completion is tested before timeout so a last free landing on the timeout cycle still counts.
  always_comb begin
    state_nx = state;
    flags_nx = flags;
    pcnt_nx  = pcnt;
    wcnt_nx  = wcnt;
    drive_nx = drive_q;
    ready_nx = o_ready;
    err_nx   = o_err;
    data_nx  = o_data;
    tok_nx   = o_tokCnt;
    case (state)
      IDLE: begin
        ready_nx = 1'b1;
        if (|free_edge) err_nx = 1'b1;
        if (i_valid && o_ready) begin
          data_nx  = i_data;
          ready_nx = 1'b0;
          flags_nx = '0;
          pcnt_nx  = '0;
          wcnt_nx  = '0;
          drive_nx = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: begin
        flags_nx = flags | free_edge;
        if (pcnt == PULSE_LAST) begin
          drive_nx = 1'b0;
          state_nx = WAIT;
        end else begin
          pcnt_nx = pcnt + PW'(1);
        end
      end
      WAIT: begin
        flags_nx = flags | free_edge;
        if (all_set) begin
          tok_nx   = o_tokCnt + CW'(1);
          wcnt_nx  = '0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else if ((TIMEOUT > 0) && (wcnt == WAIT_LAST)) begin
          err_nx   = 1'b1;
          wcnt_nx  = '0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          wcnt_nx = wcnt + WW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  assign o_drive0 = drive_q;
  assign o_drive1 = drive_q;
  assign o_drive2 = drive_q;

endmodule

// File: doc/sync_fork3_issue.md
Name: sync_fork3_issue

Overview:
- Clocked issue stage directly upstream of the three-way wait-merge micropipeline join.
- Accepts one transaction per valid/ready handshake and registers its bundled data.
- Fires a drive pulse on three parallel branch inputs, then waits until all three free returns are seen before accepting the next token.
- Provides the synchronous-to-micropipeline boundary for the merge's three input branches.

Parameters:
DW, 8, bundled data width
PULSE_W, 2, drive pulse width in clk cycles (>=1)
TIMEOUT, 16, max WAIT cycles before abort; 0 disables timeout
CW, 4, width of completed-token counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
i_valid  in  1  upstream transaction valid
o_ready  out  1  stage can accept (registered)
i_data  in  DW  upstream data
o_data  out  DW  bundled data to branches; stable from accept until return to IDLE
o_drive0  out  1  drive pulse, branch 0
o_drive1  out  1  drive pulse, branch 1
o_drive2  out  1  drive pulse, branch 2
i_free0  in  1  free from branch 0 (asynchronous)
i_free1  in  1  free from branch 1 (asynchronous)
i_free2  in  1  free from branch 2 (asynchronous)
o_busy  out  1  state != IDLE
o_err  out  1  sticky error: timeout or spurious free; cleared only by rst
o_tokCnt  out  CW  completed-token count, wraps

Behaviour:
- Reset (rst=0, async): state=IDLE; o_ready, o_drive0..2, o_busy, o_err = 0; o_data, o_tokCnt = 0; synchronizers and sticky flags = 0.
- o_ready goes 1 on the first clk edge after rst deasserts.
- Free inputs:
  - Each i_freeN passes through a 2-FF synchronizer, then rising-edge detection (sync & ~prev).
  - Recognition occurs 2-3 cycles after the input rises.
  - Input constraint: each free high and low time >= 2 clk periods.
- States: IDLE, DRIVE, WAIT.
- IDLE:
  - o_ready=1. Accept on the edge where i_valid & o_ready.
  - On accept: o_data<=i_data, o_ready<=0, sticky flags cleared, pulse counter=0, state->DRIVE.
- DRIVE:
  - o_drive0..2 all high together for exactly PULSE_W cycles, starting the cycle after accept (latency 1).
  - Then all three go low together and state->WAIT.
  - Free edges detected in DRIVE are captured into the sticky flags.
- WAIT:
  - Sticky flag N is set on the branch N free edge.
  - When all three flags are set, counting flags set in the current cycle, the state returns to IDLE on that edge. In the same edge: o_tokCnt+1 (mod 2^CW), wait counter cleared, o_ready<=1.
  - Simultaneous and staggered free edges are handled identically.
- Timeout:
  - Applies only if TIMEOUT>0. The wait counter increments each WAIT cycle.
  - When it reaches TIMEOUT without all flags set: o_err<=1, state->IDLE, o_ready<=1, o_tokCnt unchanged.
  - If completion and timeout coincide, completion wins.
- Spurious free:
  - A free edge detected in IDLE sets o_err, with no state change.
  - A second edge on an already-set flag in DRIVE/WAIT is ignored.
- i_valid is ignored outside IDLE.
- o_data never changes outside the accept edge.
- o_busy = (state != IDLE), registered with the state.
- Reset mid-operation: immediate return to reset values. Drives drop asynchronously; the in-flight token is lost and not counted.
- Minimum token period: 1 + PULSE_W + free recognition latency + 1 cycles.

Test Plan:
- Reset -> rst=0 with i_valid=1: all outputs 0. Release rst: o_ready=1 after 1 edge, no accept before then.
- Single token -> i_data=0xA5, i_valid for 1 cycle at cycle 0:
  - o_data=0xA5 at cycle 1; o_drive0..2 high in cycles 1-2, low in cycle 3.
  - All frees high for 3 cycles from cycle 5 -> o_ready=1 and o_tokCnt=1 by cycle 9.
- Staggered frees -> free0 at cycle 4, free1 at 8, free2 at 12, i_valid held high with i_data=0x3C:
  - Return to IDLE only after free2 is recognised.
  - o_data stays 0xA5 until the next accept; then 0x3C is accepted.
- Timeout -> free0 and free1 pulsed, free2 never: 16 WAIT cycles later o_err=1, state IDLE, o_tokCnt unchanged.
- Spurious and wrap -> free1 pulsed in IDLE: o_err=1, o_busy stays 0. Then 16 complete tokens with CW=4: o_tokCnt returns to 0.
- Reset mid-WAIT -> rst low while in WAIT: drives/flags/o_tokCnt=0 immediately. A following token completes normally with o_tokCnt=1.
